// File: rtl/vending_machine_18105070.sv
// ---------------------------------------------------------------------------
// vending_machine_18105070
//
// Coin-operated vending controller for a single product priced at 15 units.
// Accepts 5- and 10-unit coins, tracks credit as 0, 5 or 10 units, dispenses
// when credit reaches 15 and returns any 5-unit overpayment as change.
//
// Optional feature (compile-time macro):
//   VENDING_MACHINE_18105070_REFUND_EN
//     Defined   : a "no coin" cycle (in = 00) while credit is held refunds
//                 the whole credit through `change` and returns to S0.
//     Undefined : a "no coin" cycle simply holds the current credit.
//
// Ports:
//   clk     in   1  rising-edge clock for all state
//   rst     in   1  asynchronous active-high reset
//   in      in   2  coin code: 00 none, 01 = 5, 10 = 10, 11 invalid
//   out     out  1  product dispense, registered one-cycle pulse
//   change  out  2  registered change code: 00 none, 01 = 5, 10 = 10
//
// Outputs are registered: they reflect the decision made on the previous
// rising edge and fall back to 0/00 on the next edge unless re-asserted.
// ---------------------------------------------------------------------------
module vending_machine_18105070 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] in,
  output logic       out,
  output logic [1:0] change
);

  // Coin codes on `in`.
  localparam logic [1:0] CoinNone    = 2'b00;
  localparam logic [1:0] CoinFive    = 2'b01;
  localparam logic [1:0] CoinTen     = 2'b10;
  localparam logic [1:0] CoinInvalid = 2'b11;

  // Change codes on `change`.
  localparam logic [1:0] ChgNone = 2'b00;
  localparam logic [1:0] ChgFive = 2'b01;
  localparam logic [1:0] ChgTen  = 2'b10;

  // Credit held so far; encoding 2'b11 is unused and recovers to StS0.
  typedef enum logic [1:0] {
    StS0  = 2'b00,
    StS5  = 2'b01,
    StS10 = 2'b10
  } state_e;

  state_e     state_q;
  logic       out_q;
  logic [1:0] change_q;

  // Single registered FSM: next credit and the outputs for the following
  // cycle are all decided on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // Any held credit is discarded, never dispensed or refunded.
      state_q  <= StS0;
      out_q    <= 1'b0;
      change_q <= ChgNone;
    end else begin
      // Default: outputs are one-cycle pulses.
      out_q    <= 1'b0;
      change_q <= ChgNone;
      unique case (state_q)
        StS0: begin
          unique case (in)
            CoinFive:    state_q <= StS5;
            CoinTen:     state_q <= StS10;
            CoinNone:    state_q <= StS0;
            CoinInvalid: state_q <= StS0;
            default:     state_q <= StS0;
          endcase
        end
        StS5: begin
          unique case (in)
            CoinFive: state_q <= StS10;
            CoinTen: begin
              // Exactly 15: dispense, no change.
              state_q <= StS0;
              out_q   <= 1'b1;
            end
            CoinNone: begin
`ifdef VENDING_MACHINE_18105070_REFUND_EN
              state_q  <= StS0;
              change_q <= ChgFive;
`else
              state_q  <= StS5;
`endif
            end
            CoinInvalid: state_q <= StS5;
            default:     state_q <= StS0;
          endcase
        end
        StS10: begin
          unique case (in)
            CoinFive: begin
              state_q <= StS0;
              out_q   <= 1'b1;
            end
            CoinTen: begin
              // 20 paid: dispense and return the 5-unit overpayment.
              state_q  <= StS0;
              out_q    <= 1'b1;
              change_q <= ChgFive;
            end
            CoinNone: begin
`ifdef VENDING_MACHINE_18105070_REFUND_EN
              // Only path that ever produces a 10-unit change code.
              state_q  <= StS0;
              change_q <= ChgTen;
`else
              state_q  <= StS10;
`endif
            end
            CoinInvalid: state_q <= StS10;
            default:     state_q <= StS0;
          endcase
        end
        default: begin
          // Unreachable encoding: recover silently.
          state_q <= StS0;
        end
      endcase
    end
  end

  assign out    = out_q;
  assign change = change_q;

endmodule

// File: tb/tb_vending_machine_18105070.sv
// Directed self-checking bench for vending_machine_18105070.
// Expectations follow the refund macro, so the bench suits both builds.
module tb_vending_machine_18105070;

  logic       clk;
  logic       rst;
  logic [1:0] in;
  logic       out;
  logic [1:0] change;

  int unsigned total;
  int unsigned bad;

  localparam logic [1:0] S0  = 2'd0;
  localparam logic [1:0] S5  = 2'd1;
  localparam logic [1:0] S10 = 2'd2;

  vending_machine_18105070 dut (
    .clk    (clk),
    .rst    (rst),
    .in     (in),
    .out    (out),
    .change (change)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  // Apply one coin for one edge, then check outputs and credit 1 ns later.
  task automatic step_chk(input string tag, input logic [1:0] coin, input logic exp_out,
                          input logic [1:0] exp_chg, input logic [1:0] exp_st);
    in = coin;
    @(posedge clk);
    #1;
    check_eq({tag, ".out"}, 8'(out), 8'(exp_out));
    check_eq({tag, ".chg"}, 8'(change), 8'(exp_chg));
    check_eq({tag, ".st"}, 8'(dut.state_q), 8'(exp_st));
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    in    = 2'b01;

    // Reset held across edges with a coin present.
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst.out", 8'(out), 8'd0);
    check_eq("rst.chg", 8'(change), 8'd0);
    check_eq("rst.st", 8'(dut.state_q), 8'(S0));
    rst = 1'b0;

    // Held 5-unit coin for four edges.
    step_chk("held1", 2'b01, 1'b0, 2'b00, S5);
    step_chk("held2", 2'b01, 1'b0, 2'b00, S10);
    step_chk("held3", 2'b01, 1'b1, 2'b00, S0);
    step_chk("held4", 2'b01, 1'b0, 2'b00, S5);
    // Finish that purchase: 5 + 10.
    step_chk("fin", 2'b10, 1'b1, 2'b00, S0);

    // 10 + 10 gives change of 5, then outputs drop.
    step_chk("tt1", 2'b10, 1'b0, 2'b00, S10);
    step_chk("tt2", 2'b10, 1'b1, 2'b01, S0);
    step_chk("tt3", 2'b11, 1'b0, 2'b00, S0);

    // 5 + 10, then next coin accepted with no gap.
    step_chk("ft1", 2'b01, 1'b0, 2'b00, S5);
    step_chk("ft2", 2'b10, 1'b1, 2'b00, S0);
    step_chk("ft3", 2'b10, 1'b0, 2'b00, S10);
    step_chk("ft4", 2'b01, 1'b1, 2'b00, S0);

    // No coin in S0 never produces output.
    step_chk("idle0", 2'b00, 1'b0, 2'b00, S0);

    // Refund / hold behaviour on a no-coin cycle.
    step_chk("rf10a", 2'b10, 1'b0, 2'b00, S10);
`ifdef VENDING_MACHINE_18105070_REFUND_EN
    step_chk("rf10b", 2'b00, 1'b0, 2'b10, S0);
    step_chk("rf5a", 2'b01, 1'b0, 2'b00, S5);
    step_chk("rf5b", 2'b00, 1'b0, 2'b01, S0);
`else
    step_chk("rf10b", 2'b00, 1'b0, 2'b00, S10);
    step_chk("rf10c", 2'b01, 1'b1, 2'b00, S0);
    step_chk("rf5a", 2'b01, 1'b0, 2'b00, S5);
    step_chk("rf5b", 2'b00, 1'b0, 2'b00, S5);
    step_chk("rf5c", 2'b10, 1'b1, 2'b00, S0);
`endif

    // Invalid coins hold credit silently.
    step_chk("inv0", 2'b01, 1'b0, 2'b00, S5);
    for (int i = 0; i < 3; i++) begin
      step_chk($sformatf("inv%0d", i + 1), 2'b11, 1'b0, 2'b00, S5);
    end

    // Reset between edges discards credit; then a lone 10 must not dispense.
    rst = 1'b1;
    #2;
    check_eq("midrst.st", 8'(dut.state_q), 8'(S0));
    rst = 1'b0;
    step_chk("post1", 2'b10, 1'b0, 2'b00, S10);

    // Dispense pulse is cleared by reset without waiting for an edge.
    step_chk("pulse", 2'b01, 1'b1, 2'b00, S0);
    rst = 1'b1;
    #1;
    check_eq("async.out", 8'(out), 8'd0);
    step_chk("async1", 2'b10, 1'b0, 2'b00, S0);
    rst = 1'b0;
    step_chk("post2", 2'b10, 1'b0, 2'b00, S10);
    step_chk("post3", 2'b10, 1'b1, 2'b01, S0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
